byte_data_memory: RTL and testbench
===================================

BYTE_DATA_MEMORY -- requirements
Module: byte_data_memory

Interface
REQ-001 Parameters SHALL be exactly as listed (name, default, meaning):
- DEPTH_WORDS, 32: number of 32-bit words; power of two, 4..4096.
- INIT_PATTERN, 1: 1 = word i initialised to i; 0 = all words initialised to zero.
REQ-002 Ports SHALL be exactly as listed (name, direction, width, meaning):
- clock, in, 1: single clock; all state on rising edge.
- reset, in, 1: asynchronous, active-low reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: block can accept a request.
- mem_write, in, 1: store request.
- mem_read, in, 1: load request.
- funct3, in, 3: access size and sign (RV32I load/store encoding).
- address, in, 32: byte address.
- write_data, in, 32: store data, right-aligned.
- result, out, 32: load data, aligned and extended.
- result_valid, out, 1: one-cycle pulse when result is new.
- access_fault, out, 1: one-cycle pulse on a rejected access.
- init_done, out, 1: initialisation sweep finished.

Function
REQ-003 The FSM SHALL have exactly two states, INIT and READY; INIT SHALL be entered on reset.
REQ-004 INIT SHALL write one word per cycle using counter values 0..DEPTH_WORDS-1, with the value set by INIT_PATTERN, then move to READY; INIT SHALL last exactly DEPTH_WORDS cycles.
REQ-005 In READY, req_ready SHALL be 1 and init_done SHALL be 1; in INIT, both SHALL be 0; requests presented in INIT SHALL be ignored.
REQ-006 An access SHALL be accepted on a rising edge where req_valid=1, req_ready=1, and mem_write or mem_read is 1.
REQ-007 The word index SHALL be address[log2(DEPTH_WORDS)+1:2]; higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-008 Store sizes: SB (000) SHALL write only the byte lane address[1:0]; SH (001) SHALL write only the halfword lane address[1]; SW (010) SHALL write all four lanes; the memory SHALL update on the accept edge.
REQ-009 Load sizes: LB (000) and LH (001) SHALL sign-extend; LBU (100) and LHU (101) SHALL zero-extend; LW (010) SHALL return the full word.
REQ-010 Load latency SHALL be one cycle: result and a result_valid pulse SHALL appear on the edge after acceptance.
REQ-011 result SHALL hold its last value while result_valid=0.
REQ-012 If mem_write and mem_read are both 1, the store SHALL win, and result_valid SHALL stay 0.
REQ-013 A fault SHALL be any of: halfword access with address[0]=1; word access with address[1:0]!=0; funct3 011, 110 or 111; or a store with funct3 100 or 101.
REQ-014 On a fault, memory SHALL be unchanged, result SHALL be unchanged, result_valid SHALL be 0, and access_fault SHALL pulse in the latency-1 cycle.
REQ-015 Back-to-back accepts SHALL be supported every cycle.
REQ-016 A load of a word stored on the previous edge SHALL return the new data.

Reset
REQ-017 While reset=0: FSM=INIT, init counter=0, result=0, result_valid=0, access_fault=0, req_ready=0, init_done=0.
REQ-018 Assertion of reset mid-INIT or mid-access SHALL abort the operation, and the sweep SHALL restart from word 0 after deassertion.
REQ-019 Memory contents are defined only after init_done=1.

Structure
REQ-020 A shared package data_memory_pkg SHALL hold the funct3 encodings (LB/LH/LW/LBU/LHU/SB/SH/SW) and the FSM state enum.
REQ-021 One combinational sub-module, mem_lane_align, SHALL produce the byte-enable/write-data alignment, the load extraction/extension and the fault decode.
REQ-022 The storage array SHALL be a single word-wide array with per-byte write enables.

Verification
REQ-023 The bench SHALL cover these directed scenarios:
- Reset release, DEPTH_WORDS=32, INIT_PATTERN=1 -> init_done rises 32 cycles later; LW at address 0x14 -> result=0x00000005 one cycle after accept.
- SW 0x8899AABB at 0x20, then SB 0x7F at 0x23 -> LW 0x20 returns 0x7F99AABB; LB 0x21 returns 0xFFFFFFAA; LBU 0x21 returns 0x000000AA.
- SH 0x8001 at 0x42, then LH 0x42 -> 0xFFFF8001; LHU 0x42 -> 0x00008001.
- LW at 0x06, SH at 0x03, and funct3=111 -> access_fault pulses each time; memory and result unchanged; result_valid stays 0.
- mem_write=mem_read=1, SW 0x1234 at 0x80 (wraps to word 0) -> no result_valid; next LW 0x00 returns 0x00001234.
- reset pulled low during INIT at counter 10 -> after release, init_done rises exactly 32 cycles later.

Source files
------------

// File: rtl/data_memory_pkg.sv
// data_memory_pkg: funct3 encodings and FSM state shared by the byte data memory.
package data_memory_pkg;
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    typedef enum logic {INIT, READY} state_t;
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane steering, load extraction/extension and access fault decode.
module mem_lane_align
    import data_memory_pkg::*;
(
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] write_data,
    output logic [3:0]  byte_en,
    output logic [31:0] store_word,
    output logic        fault,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_offset,
    input  logic [31:0] read_word,
    output logic [31:0] load_data
);
    logic bad_f3, misaligned, sx;
    logic [7:0] ld_byte;
    logic [15:0] ld_half;
    always_comb begin
        bad_f3 = is_store ? !(funct3 inside {F3_SB, F3_SH, F3_SW})
                          : !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
        misaligned = (funct3[1:0] == 2'b01 && offset[0]) || (funct3[1:0] == 2'b10 && offset != 2'b00);
        fault = bad_f3 || misaligned;
        byte_en = funct3[1] ? 4'b1111 : funct3[0] ? (offset[1] ? 4'b1100 : 4'b0011) : 4'b0001 << offset;
        store_word = funct3[1] ? write_data : funct3[0] ? {2{write_data[15:0]}} : {4{write_data[7:0]}};
        ld_byte = read_word[{ld_offset, 3'b000} +: 8];
        ld_half = ld_offset[1] ? read_word[31:16] : read_word[15:0];
        sx = !ld_funct3[2];
        load_data = ld_funct3[1] ? read_word
                  : ld_funct3[0] ? {{16{sx & ld_half[15]}}, ld_half}
                  : {{24{sx & ld_byte[7]}}, ld_byte};
    end
endmodule

// File: rtl/byte_data_memory.sv
// byte_data_memory: byte-addressable RV32I data memory with init sweep and one-cycle loads.
module byte_data_memory
    import data_memory_pkg::*;
#(
    parameter int DEPTH_WORDS  = 32,
    parameter int INIT_PATTERN = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        mem_write,
    input  logic        mem_read,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] result,
    output logic        result_valid,
    output logic        access_fault,
    output logic        init_done
);
    localparam int AW = $clog2(DEPTH_WORDS);
    state_t state;
    logic [31:0] mem [DEPTH_WORDS];
    logic [AW-1:0] cnt, idx, widx, p_idx;
    logic [2:0] p_f3;
    logic [1:0] p_off;
    logic p_load, p_fault, accept, fault, do_store, do_load;
    logic [3:0] be, we;
    logic [31:0] st_word, wword, ld_data;
    logic unused_addr;
    assign idx = address[AW+1:2];
    assign unused_addr = ^address[31:AW+2];
    assign req_ready = state == READY;
    assign init_done = state == READY;
    assign accept = req_valid && state == READY && (mem_write || mem_read);
    assign do_store = accept && mem_write && !fault;
    assign do_load = accept && !mem_write && mem_read && !fault;
    // The init sweep owns the write port until READY; requests cannot reach it then.
    assign widx = state == INIT ? cnt : idx;
    assign we = state == INIT ? 4'b1111 : do_store ? be : 4'b0000;
    assign wword = state == INIT ? (INIT_PATTERN != 0 ? 32'(cnt) : 32'h0) : st_word;

    mem_lane_align u_align (
        .is_store   (mem_write),
        .funct3     (funct3),
        .offset     (address[1:0]),
        .write_data (write_data),
        .byte_en    (be),
        .store_word (st_word),
        .fault      (fault),
        .ld_funct3  (p_f3),
        .ld_offset  (p_off),
        .read_word  (mem[p_idx]),
        .load_data  (ld_data)
    );

    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++)
            if (we[b]) mem[widx][8*b +: 8] <= wword[8*b +: 8];
    end

    // Loads read the array one edge after acceptance, so a store on the accept edge is visible.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= INIT;
            cnt <= '0;
            p_load <= 1'b0;
            p_fault <= 1'b0;
            p_idx <= '0;
            p_f3 <= '0;
            p_off <= '0;
            result <= '0;
            result_valid <= 1'b0;
            access_fault <= 1'b0;
        end else begin
            if (state == INIT) begin
                cnt <= cnt + AW'(1);
                if (cnt == AW'(DEPTH_WORDS - 1)) state <= READY;
            end
            p_load <= do_load;
            p_fault <= accept && fault;
            if (do_load) begin
                p_idx <= idx;
                p_f3 <= funct3;
                p_off <= address[1:0];
            end
            result_valid <= p_load;
            access_fault <= p_fault;
            if (p_load) result <= ld_data;
        end
    end
endmodule

// File: tb/tb_byte_data_memory.sv
// tb_byte_data_memory: directed scoreboard bench for byte_data_memory.
module tb_byte_data_memory;
    import data_memory_pkg::*;
    typedef struct {
        logic        f;
        logic [31:0] v;
        string       tag;
    } exp_t;
    logic clock = 1'b0;
    logic reset = 1'b0;
    logic req_valid = 1'b0, mem_write = 1'b0, mem_read = 1'b0;
    logic [2:0] funct3 = '0;
    logic [31:0] address = '0, write_data = '0;
    logic req_ready, result_valid, access_fault, init_done;
    logic [31:0] result;
    int checks = 0;
    int errors = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] last_res = '0;

    byte_data_memory #(.DEPTH_WORDS(32), .INIT_PATTERN(1)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .funct3       (funct3),
        .address      (address),
        .write_data   (write_data),
        .result       (result),
        .result_valid (result_valid),
        .access_fault (access_fault),
        .init_done    (init_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) last_res = '0;
        else if (result_valid || access_fault) begin
            if (q.size() == 0) check("unexpected_output", {30'b0, result_valid, access_fault}, 32'h0);
            else begin
                e = q.pop_front();
                check({e.tag, "_kind"}, {30'b0, result_valid, access_fault}, e.f ? 32'h1 : 32'h2);
                if (e.f) check({e.tag, "_result_held"}, result, last_res);
                else begin
                    check(e.tag, result, e.v);
                    last_res = e.v;
                end
            end
        end
    end

    task automatic drive(input logic w, input logic r, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        req_valid = 1'b1; mem_write = w; mem_read = r; funct3 = f3; address = a; write_data = wd;
        @(posedge clock); #1;
        req_valid = 1'b0; mem_write = 1'b0; mem_read = 1'b0;
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        drive(1'b1, 1'b0, f3, a, wd);
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] exp, input string tag);
        q.push_back('{1'b0, exp, tag});
        drive(1'b0, 1'b1, f3, a, 32'h0);
    endtask

    task automatic bad(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input string tag);
        q.push_back('{1'b1, 32'h0, tag});
        drive(w, !w, f3, a, wd);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 8 && q.size() > 0; i++) @(negedge clock);
        repeat (2) @(negedge clock);
        check(tag, 32'(q.size()), 32'h0);
        q.delete();
    endtask

    // Releases reset and counts edges until init_done, with a store held on the bus meanwhile.
    task automatic release_and_time(input string tag);
        int n;
        n = 0;
        reset = 1'b1;
        req_valid = 1'b1; mem_write = 1'b1; funct3 = F3_SW; address = 32'h0C; write_data = 32'hDEADBEEF;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            n++;
            @(negedge clock);
            if (init_done) break;
        end
        req_valid = 1'b0; mem_write = 1'b0;
        check(tag, 32'(n), 32'd32);
        check({tag, "_ready"}, {31'b0, req_ready}, 32'h1);
    endtask

    initial begin
        repeat (3) @(posedge clock);
        #1;
        check("rst_req_ready", {31'b0, req_ready}, 32'h0);
        check("rst_init_done", {31'b0, init_done}, 32'h0);
        check("rst_result", result, 32'h0);
        check("rst_result_valid", {31'b0, result_valid}, 32'h0);
        check("rst_access_fault", {31'b0, access_fault}, 32'h0);
        release_and_time("init_latency");

        ld(F3_LW, 32'h14, 32'h00000005, "lw_0x14");
        ld(F3_LW, 32'h0C, 32'h00000003, "lw_init_store_ignored");
        st(F3_SW, 32'h20, 32'h8899AABB);
        st(F3_SB, 32'h23, 32'h0000007F);
        ld(F3_LW, 32'h20, 32'h7F99AABB, "lw_0x20");
        ld(F3_LB, 32'h21, 32'hFFFFFFAA, "lb_0x21");
        ld(F3_LBU, 32'h21, 32'h000000AA, "lbu_0x21");
        st(F3_SH, 32'h42, 32'h00008001);
        ld(F3_LH, 32'h42, 32'hFFFF8001, "lh_0x42");
        ld(F3_LHU, 32'h42, 32'h00008001, "lhu_0x42");
        ld(F3_LW, 32'h40, 32'h80010010, "lw_0x40");
        drain("drain_basic");

        bad(1'b0, F3_LW, 32'h06, 32'h0, "fault_lw_0x06");
        bad(1'b1, F3_SH, 32'h03, 32'h0000FFFF, "fault_sh_0x03");
        bad(1'b0, 3'b111, 32'h00, 32'h0, "fault_f3_111");
        bad(1'b1, F3_LBU, 32'h14, 32'h000000FF, "fault_store_f3_100");
        ld(F3_LW, 32'h00, 32'h00000000, "lw_0x00_after_faults");
        ld(F3_LW, 32'h14, 32'h00000005, "lw_0x14_after_faults");
        drain("drain_faults");

        drive(1'b1, 1'b1, F3_SW, 32'h80, 32'h00001234);
        ld(F3_LW, 32'h00, 32'h00001234, "lw_0x00_after_both");
        ld(F3_LW, 32'h80, 32'h00001234, "lw_0x80_wrap");
        drain("drain_both");

        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (10) @(posedge clock);
        #1;
        reset = 1'b0;
        @(posedge clock);
        #1;
        check("midinit_rst_init_done", {31'b0, init_done}, 32'h0);
        check("midinit_rst_result", result, 32'h0);
        release_and_time("reinit_latency");
        ld(F3_LW, 32'h00, 32'h00000000, "lw_0x00_reinit");
        ld(F3_LW, 32'h20, 32'h00000008, "lw_0x20_reinit");
        ld(F3_LW, 32'h40, 32'h00000010, "lw_0x40_reinit");
        drain("drain_reinit");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
